// File: rtl/psum_pkg.sv
// psum_pkg: shared types and helpers for the partial-sum read-modify-write
// controller.
//   PSUM_AW / PSUM_DW  : default address and psum widths. The tracker entry
//                        struct is sized from these, so a different width must
//                        be changed here as well as on the top's parameters.
//   PSUM_PIPELINED     : default RAM pipelining.
//   RAM_LAT            : RAM read latency for the default pipelining.
//   psum_entry_t       : one in-flight update (valid, addr, data, clear).
//   ram_lat()          : read latency for a given Pipelined setting.
//   add_ovf()          : signed-overflow detect from the operand/result signs.
package psum_pkg;

  localparam int unsigned PSUM_AW        = 6;
  localparam int unsigned PSUM_DW        = 20;
  localparam int unsigned PSUM_PIPELINED = 0;
  localparam int unsigned RAM_LAT        = 1 + PSUM_PIPELINED;

  typedef struct packed {
    logic               valid;
    logic [PSUM_AW-1:0] addr;
    logic [PSUM_DW-1:0] data;
    logic               clear;
  } psum_entry_t;

  function automatic int unsigned ram_lat(input int unsigned pipelined);
    return 1 + pipelined;
  endfunction

  // Two's-complement add overflows only when both operands share a sign and
  // the result's sign differs from it.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/psum_hazard_tracker.sv
// psum_hazard_tracker: shift register of in-flight updates.
// Stage 0 is the entry being accepted this cycle (combinational input);
// stages 1..Lat are registered, so an entry accepted at t sits in stage Lat
// during t+Lat, which is exactly its write-back cycle.
//   clk_i, rst_ni : clock, synchronous active-low reset (discards all entries)
//   push_entry    : stage-0 entry; its valid bit is the accept strobe
//   probe_addr    : address presented on the update port
//   hazard        : probe_addr matches a valid registered stage
//   wb_entry      : stage-Lat entry (write-back candidate)
//   busy          : any registered stage valid
module psum_hazard_tracker
  import psum_pkg::*;
#(
  parameter int unsigned Lat = RAM_LAT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  psum_entry_t        push_entry,
  input  logic [PSUM_AW-1:0] probe_addr,
  output logic               hazard,
  output psum_entry_t        wb_entry,
  output logic               busy
);

  psum_entry_t [Lat:1] pipe;
  logic        [Lat:1] hit;
  logic        [Lat:1] vld;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe <= '0;
    end else begin
      pipe[1] <= push_entry;
      for (int s = 2; s <= Lat; s++) pipe[s] <= pipe[s-1];
    end
  end

  // Stage 0 is the requester itself, so only registered stages can collide.
  // A match on stage Lat still stalls: its write lands this cycle and a read
  // issued now would see the old word.
  for (genvar s = 1; s <= Lat; s++) begin : g_stage
    assign vld[s] = pipe[s].valid;
    assign hit[s] = pipe[s].valid && (pipe[s].addr == probe_addr);
  end

  assign hazard   = |hit;
  assign busy     = |vld;
  assign wb_entry = pipe[Lat];

endmodule

// File: rtl/psum_rmw_ctrl.sv
// psum_rmw_ctrl: read-modify-write controller using a true dual-port RAM as a
// partial-sum accumulator. Updates add into (or overwrite) a word and write it
// back RAM-latency cycles later; a separate drain port reads finished sums.
//   clk_i, rst_ni           : clock, synchronous active-low reset
//   upd_valid_i/upd_ready_o : update handshake
//   upd_addr_i/upd_data_i   : target word and addend (or new value)
//   upd_clear_i             : 1 = overwrite, 0 = accumulate
//   drn_valid_i/drn_addr_i  : drain read request (always accepted)
//   drn_valid_o/drn_data_o  : drained word, RAM-latency cycles later
//   busy_o                  : updates in flight
//   ovf_o/ovf_clr_i         : sticky signed-overflow flag and its clear
//   ram_*                   : initiator side of the dual-port RAM
//                             (port A = RMW, port B = drain read only)
// All outputs are forced low while rst_ni is low, including the cycle in which
// reset is first sampled, so no stale write-back can escape.
module psum_rmw_ctrl
  import psum_pkg::*;
#(
  parameter int unsigned AddrWidth = PSUM_AW,
  parameter int unsigned DataWidth = PSUM_DW,
  parameter int unsigned Pipelined = PSUM_PIPELINED
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // update port
  input  logic                 upd_valid_i,
  output logic                 upd_ready_o,
  input  logic [AddrWidth-1:0] upd_addr_i,
  input  logic [DataWidth-1:0] upd_data_i,
  input  logic                 upd_clear_i,
  // drain port
  input  logic                 drn_valid_i,
  input  logic [AddrWidth-1:0] drn_addr_i,
  output logic                 drn_valid_o,
  output logic [DataWidth-1:0] drn_data_o,
  // status
  output logic                 busy_o,
  output logic                 ovf_o,
  input  logic                 ovf_clr_i,
  // RAM port A
  output logic                 ram_re_a_o,
  output logic [AddrWidth-1:0] ram_addr_r_a_o,
  input  logic [DataWidth-1:0] ram_data_a_i,
  output logic                 ram_we_a_o,
  output logic [AddrWidth-1:0] ram_addr_w_a_o,
  output logic [DataWidth-1:0] ram_data_a_o,
  // RAM port B
  output logic                 ram_re_b_o,
  output logic [AddrWidth-1:0] ram_addr_r_b_o,
  input  logic [DataWidth-1:0] ram_data_b_i,
  output logic                 ram_we_b_o
);

  localparam int unsigned Lat = ram_lat(Pipelined);

  psum_entry_t          push_entry;
  psum_entry_t          wb_entry;
  logic                 hazard;
  logic                 busy;
  logic                 accept;
  logic                 wb_fire;
  logic [DataWidth-1:0] sum;
  logic                 ovf_hit;
  logic                 ovf_q;
  logic [Lat:1]         drn_pipe;

  // ---------------- accept / tracker ----------------
  assign upd_ready_o = rst_ni & ~hazard;
  assign accept      = upd_valid_i & upd_ready_o;

  always_comb begin
    push_entry       = '0;
    push_entry.valid = accept;
    push_entry.addr  = upd_addr_i;
    push_entry.data  = upd_data_i;
    push_entry.clear = upd_clear_i;
  end

  psum_hazard_tracker #(
    .Lat(Lat)
  ) u_tracker (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_entry (push_entry),
    .probe_addr (upd_addr_i),
    .hazard     (hazard),
    .wb_entry   (wb_entry),
    .busy       (busy)
  );

  assign busy_o = rst_ni & busy;

  // Clear-mode updates never read: the old word is discarded anyway.
  assign ram_re_a_o     = accept & ~upd_clear_i;
  assign ram_addr_r_a_o = ram_re_a_o ? upd_addr_i : '0;

  // ---------------- write-back ----------------
  // The read issued at accept returns exactly when the entry reaches the last
  // tracker stage, so ram_data_a_i lines up with wb_entry without extra flops.
  assign sum     = ram_data_a_i + wb_entry.data;
  assign wb_fire = rst_ni & wb_entry.valid;

  assign ram_we_a_o     = wb_fire;
  assign ram_addr_w_a_o = wb_fire ? wb_entry.addr : '0;
  assign ram_data_a_o   = !wb_fire       ? '0 :
                          wb_entry.clear ? wb_entry.data : sum;

  // ---------------- overflow flag ----------------
  assign ovf_hit = wb_fire & ~wb_entry.clear &
                   add_ovf(ram_data_a_i[DataWidth-1], wb_entry.data[DataWidth-1],
                           sum[DataWidth-1]);

  // A new overflow in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)        ovf_q <= 1'b0;
    else if (ovf_hit)   ovf_q <= 1'b1;
    else if (ovf_clr_i) ovf_q <= 1'b0;
  end

  assign ovf_o = rst_ni & ovf_q;

  // ---------------- drain ----------------
  assign ram_re_b_o     = rst_ni & drn_valid_i;
  assign ram_addr_r_b_o = ram_re_b_o ? drn_addr_i : '0;
  assign ram_we_b_o     = 1'b0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drn_pipe <= '0;
    end else begin
      drn_pipe[1] <= ram_re_b_o;
      for (int s = 2; s <= Lat; s++) drn_pipe[s] <= drn_pipe[s-1];
    end
  end

  // RAM data passes straight through: no forwarding from in-flight updates.
  assign drn_valid_o = rst_ni & drn_pipe[Lat];
  assign drn_data_o  = drn_valid_o ? ram_data_b_i : '0;

endmodule

// File: tb/tb_psum_rmw_ctrl.sv
// Bench for psum_rmw_ctrl. Two instances (Pipelined = 0 and 1) each run a
// directed prologue and then random traffic against a RAM model; expected
// values come from a sequential accumulator model plus a write schedule.
module tb_psum_rmw_ctrl;

  localparam int AW    = 6;
  localparam int DW    = 20;
  localparam int DEPTH = 1 << AW;
  localparam int N_DIR = 39;
  localparam int NRAND = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 1) return 20'h7FFFF;
    if (a == 3) return 20'd10;
    if (a == 5) return 20'd1234;
    return DW'(a * 7919 + 13);
  endfunction

  typedef struct {
    bit v; int addr; int data; bit clr;
    bit drn; int daddr; bit oclr; bit rst;
  } vec_t;

  typedef struct { int due; int addr; logic [DW-1:0] val; bit ovf; } wr_t;
  typedef struct { int due; int addr; logic [DW-1:0] val; bit ok;  } rd_t;

  function automatic vec_t dvec(input int i);
    vec_t v = '{default: 0};
    case (i)
      0:       begin v.v = 1; v.addr = 3; v.data = 5; end
      4, 11:   begin v.drn = 1; v.daddr = 3; end
      5, 6, 7: begin v.v = 1; v.addr = 3; v.data = 1; end
      12:      begin v.v = 1; v.addr = 5; v.data = 7; v.clr = 1; end
      13:      begin v.v = 1; v.addr = 5; v.data = 2; end
      17:      begin v.drn = 1; v.daddr = 5; end
      18:      begin v.v = 1; v.addr = 1; v.data = 1; end
      22:      v.oclr = 1;
      35:      begin v.v = 1; v.addr = 9; v.data = 3; end
      36:      v.rst = 1;
      38:      begin v.drn = 1; v.daddr = 9; end
      default: if (i >= 24 && i <= 31) begin v.v = 1; v.addr = i - 16; v.data = i; end
    endcase
    return v;
  endfunction

  function automatic vec_t rvec();
    vec_t v = '{default: 0};
    v.rst   = ($urandom_range(0, 199) == 0);
    v.v     = ($urandom_range(0, 3) != 0);
    v.addr  = $urandom_range(0, 7);
    v.clr   = ($urandom_range(0, 5) == 0);
    v.data  = ($urandom_range(0, 9) == 0) ? int'($urandom) : int'($urandom_range(0, 63)) - 32;
    v.drn   = ($urandom_range(0, 2) == 0);
    v.daddr = $urandom_range(0, 7);
    v.oclr  = ($urandom_range(0, 19) == 0);
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = g + 1;

    logic          rst_n, upd_valid, upd_ready, upd_clear, ovf_clr;
    logic          drn_valid_in, drn_valid_out, busy, ovf;
    logic [AW-1:0] upd_addr, drn_addr, ra_a, wa_a, ra_b;
    logic [DW-1:0] upd_data, drn_data, rd_a, wd_a, rd_b;
    logic          re_a, we_a, re_b, we_b;
    logic          init_en;
    bit            fin = 1'b0;

    // RAM model: registered read, extra output register when pipelined.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] qa0, qa1, qb0, qb1;

    always @(posedge clk) begin
      if (init_en) for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
      else if (we_a) mem[wa_a] <= wd_a;
      if (re_a) qa0 <= mem[ra_a];
      if (re_b) qb0 <= mem[ra_b];
      qa1 <= qa0;
      qb1 <= qb0;
    end

    assign rd_a = (L == 2) ? qa1 : qa0;
    assign rd_b = (L == 2) ? qb1 : qb0;

    psum_rmw_ctrl #(
      .AddrWidth (AW),
      .DataWidth (DW),
      .Pipelined (g)
    ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .upd_valid_i    (upd_valid),
      .upd_ready_o    (upd_ready),
      .upd_addr_i     (upd_addr),
      .upd_data_i     (upd_data),
      .upd_clear_i    (upd_clear),
      .drn_valid_i    (drn_valid_in),
      .drn_addr_i     (drn_addr),
      .drn_valid_o    (drn_valid_out),
      .drn_data_o     (drn_data),
      .busy_o         (busy),
      .ovf_o          (ovf),
      .ovf_clr_i      (ovf_clr),
      .ram_re_a_o     (re_a),
      .ram_addr_r_a_o (ra_a),
      .ram_data_a_i   (rd_a),
      .ram_we_a_o     (we_a),
      .ram_addr_w_a_o (wa_a),
      .ram_data_a_o   (wd_a),
      .ram_re_b_o     (re_b),
      .ram_addr_r_b_o (ra_b),
      .ram_data_b_i   (rd_b),
      .ram_we_b_o     (we_b)
    );

    initial begin : stim
      logic [DW-1:0] ref_mem [DEPTH];   // value after all accepted updates
      logic [DW-1:0] com_mem [DEPTH];   // value actually written to RAM so far
      wr_t           pend [$];
      rd_t           drq [$];
      vec_t          v;
      logic [DW-1:0] d, old_v, new_v;
      bit            ovf_m, rst, hz, acc, do_wr, dv, set, ok, ovfl;
      int            c, di, nr;

      rst_n = 1'b0; init_en = 1'b1;
      upd_valid = 0; upd_addr = '0; upd_data = '0; upd_clear = 0;
      drn_valid_in = 0; drn_addr = '0; ovf_clr = 0;
      for (int a = 0; a < DEPTH; a++) begin
        ref_mem[a] = init_val(a);
        com_mem[a] = init_val(a);
      end
      @(posedge clk); #1 init_en = 1'b0;
      @(negedge clk);
      chk("rst_ready", upd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_we_a", we_a, 0);
      chk("rst_re_a", re_a, 0);
      chk("rst_drn_v", drn_valid_out, 0);
      chk("rst_ovf", ovf, 0);

      ovf_m = 0; c = 0; di = 0; nr = 0;
      while ((di < N_DIR || nr < NRAND) && c < 8000) begin
        @(posedge clk); #1;
        v = (di < N_DIR) ? dvec(di) : rvec();
        rst_n        = !v.rst;
        upd_valid    = v.v;
        upd_addr     = AW'(v.addr);
        upd_data     = DW'(v.data);
        upd_clear    = v.clr;
        drn_valid_in = v.drn;
        drn_addr     = AW'(v.daddr);
        ovf_clr      = v.oclr;
        @(negedge clk);

        rst = !v.rst;
        hz = 0;
        foreach (pend[k]) if (pend[k].addr == v.addr) hz = 1;
        chk("upd_ready", upd_ready, rst && !hz);
        acc = v.v && rst && !hz;
        chk("re_a", re_a, acc && !v.clr);
        if (acc && !v.clr) chk("ra_a", ra_a, v.addr);

        do_wr = rst && pend.size() > 0 && pend[0].due == c;
        chk("we_a", we_a, do_wr);
        if (do_wr) begin
          chk("wa_a", wa_a, pend[0].addr);
          chk("wd_a", wd_a, pend[0].val);
        end
        chk("busy", busy, rst && pend.size() > 0);
        chk("ovf", ovf, rst && ovf_m);
        chk("we_b", we_b, 0);
        chk("re_b", re_b, rst && v.drn);
        if (rst && v.drn) chk("ra_b", ra_b, v.daddr);

        dv = rst && drq.size() > 0 && drq[0].due == c;
        chk("drn_valid", drn_valid_out, dv);
        if (dv && drq[0].ok) chk("drn_data", drn_data, drq[0].val);
        if (dv) void'(drq.pop_front());

        if (!rst) begin
          // In-flight work is discarded; RAM keeps what was already written.
          pend.delete();
          drq.delete();
          for (int a = 0; a < DEPTH; a++) ref_mem[a] = com_mem[a];
          ovf_m = 0;
        end else begin
          if (v.drn) begin
            ok = !(do_wr && pend[0].addr == v.daddr);
            drq.push_back('{c + L, v.daddr, com_mem[v.daddr], ok});
          end
          set = 0;
          if (do_wr) begin
            com_mem[pend[0].addr] = pend[0].val;
            set = pend[0].ovf;
            void'(pend.pop_front());
          end
          ovf_m = set || (ovf_m && !v.oclr);
          if (acc) begin
            d     = DW'(v.data);
            old_v = ref_mem[v.addr];
            if (v.clr) begin
              new_v = d;
              ovfl  = 0;
            end else begin
              new_v = old_v + d;
              ovfl  = ($signed(old_v) < 0) == ($signed(d) < 0) &&
                      ($signed(new_v) < 0) != ($signed(old_v) < 0);
            end
            ref_mem[v.addr] = new_v;
            pend.push_back('{c + L, v.addr, new_v, ovfl});
          end
        end

        if (di < N_DIR) begin
          if (!v.v || acc) di++;
        end else begin
          nr++;
        end
        c++;
      end
      chk("run_len", {31'd0, di == N_DIR && nr == NRAND}, 1);
      fin = 1'b1;
    end
  end

  initial begin : finish_blk
    int cyc = 0;
    while (!(g_inst[0].fin && g_inst[1].fin) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    chk("finish", {31'd0, g_inst[0].fin && g_inst[1].fin}, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psum_rmw_ctrl.md
# psum_rmw_ctrl

Read-modify-write controller that drives a true dual-port `RAM_DP_RW` instance as a partial-sum accumulator for the PE array. Incoming (address, value) updates are added to the stored word, or overwrite it in clear mode, and written back. A separate drain port reads finished sums out. The block is the initiator side of the `RAM_DP_RW` interface and sits between the PE psum outputs and the output-activation path.

## Interface
- `AddrWidth`, 6: RAM address width; depth is 2^AddrWidth words.
- `DataWidth`, 20: psum width, two's complement.
- `Pipelined`, 0: must equal the RAM's `Pipelined`. RAM read latency is L = 1 + Pipelined cycles.
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `upd_valid_i` in 1: update request valid.
- `upd_ready_o` out 1: update accepted when valid and ready are both high.
- `upd_addr_i` in AddrWidth: target word address.
- `upd_data_i` in DataWidth: addend, or new value when `upd_clear_i` is high.
- `upd_clear_i` in 1: 1 means overwrite the word; 0 means accumulate into it.
- `drn_valid_i` in 1: drain read request; always accepted.
- `drn_addr_i` in AddrWidth: drain address.
- `drn_valid_o` out 1: drain data valid.
- `drn_data_o` out DataWidth: drained word.
- `busy_o` out 1: one or more updates are in flight.
- `ovf_o` out 1: sticky signed-overflow flag.
- `ovf_clr_i` in 1: clears `ovf_o`.
- RAM side, driving `RAM_DP_RW`:
  - `ram_re_a_o`, `ram_addr_r_a_o`, `ram_data_a_i`: port A read, used by RMW.
  - `ram_we_a_o`, `ram_addr_w_a_o`, `ram_data_a_o`: port A write, used for write-back.
  - `ram_re_b_o`, `ram_addr_r_b_o`, `ram_data_b_i`: port B read, used by drain.
  - `ram_we_b_o`: tied to 0.

## Operation
- Accept at cycle t:
  - Accumulate mode: drive `ram_re_a_o`=1 and `ram_addr_r_a_o`=addr at t.
  - Clear mode: issue no read.
  - The entry (addr, data, clear) enters tracker stage 0.
- Write-back at cycle t+L:
  - Accumulate: `ram_data_a_o` = `ram_data_a_i` + data.
  - Clear: `ram_data_a_o` = data.
  - `ram_we_a_o`=1 and `ram_addr_w_a_o`=addr in the same cycle.
- Arithmetic: DataWidth-bit two's-complement add, result wraps.
  - Signed overflow (operands of equal sign, result of opposite sign) sets `ovf_o` in cycle t+L+1.
  - `ovf_clr_i` clears `ovf_o`; a set in the same cycle wins.
- Hazard stall: `upd_ready_o`=0 while `upd_addr_i` equals the address of any valid tracker entry in stages 0..L. Otherwise `upd_ready_o`=1.
  - Throughput is one update per cycle for distinct addresses.
  - Back-to-back updates to the same address sustain one per L+1 cycles.
- Clear entries also stall same-address successors. Ordering is always strict by acceptance order.
- Drain:
  - `drn_valid_i` at cycle d drives `ram_re_b_o`=1 and `ram_addr_r_b_o`=addr.
  - `drn_valid_o`=1 and `drn_data_o` = `ram_data_b_i` at d+L.
  - Drain returns RAM content only, with no forwarding. Software drains only after `busy_o`=0.
- `busy_o` = OR of all tracker valid bits.

## Timing
- Update latency: accept to RAM write is L cycles. The written value is visible to a port-B read issued at t+L+1 or later.
- A drain read of an address whose write-back occurs in the same cycle returns undefined data. This is a legal bench case; do not check the value.
- Reset values: `upd_ready_o`=0 during reset and 1 from the first cycle after release. All other outputs are 0 during reset, including all `ram_*_o` enables, `drn_valid_o`, `busy_o` and `ovf_o`.
- Reset mid-operation:
  - All tracker entries are discarded.
  - No write-back fires in the reset cycle or afterwards for discarded entries.
  - RAM contents are left undefined and untouched.
- Drain and update may be simultaneous every cycle. The two ports are independent.

## Structure
- Shared package `psum_pkg`:
  - tracker entry struct: valid, addr, data, clear.
  - localparam `RAM_LAT` = 1 + Pipelined.
  - overflow-detect function.
- Sub-module `psum_hazard_tracker`:
  - RAM_LAT+1-stage shift register of entries.
  - Per-stage address comparators.
  - Outputs a hazard flag and the stage-L entry.
- Top level: adder and write-back mux, drain delay line (RAM_LAT flops of valid), overflow flag register.
- The RAM itself is instantiated by the parent.

## Test plan
- Pipelined=0, mem[3]=10. Update (3, +5, acc) -> write 15 at t+1; drain(3) later -> 15.
- Updates (3, +1), (3, +1), (3, +1) presented back-to-back -> `upd_ready_o` low 1 cycle between each; final mem[3] = init+3; writes at t+1, t+3, t+5.
- Pipelined=1: distinct addresses 0..7, one per cycle -> no stalls; writes at t+2; `busy_o` falls 3 cycles after the last accept.
- Clear (5, 0x00007) then acc (5, +2) -> mem[5]=9; no port-A read for the clear.
- DataWidth=20, mem[1]=0x7FFFF, update +1 -> result 0x80000 and `ovf_o`=1 next cycle; `ovf_clr_i` -> 0.
- Assert `rst_ni`=0 one cycle after an accept -> no `ram_we_a_o` pulse; all outputs 0; `upd_ready_o`=1 after release.
